// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary PWM pair with dead time, shadowed settings and fault shutdown
module pwm_deadtime_gen #(
    parameter int DT_W = 8
) (
    input  logic            pwm_clk,
    input  logic            sys_rst_n,
    input  logic            i_pwm_en,
    input  logic            i_period_evt,
    input  logic            i_duty_evt,
    input  logic [DT_W-1:0] i_dt_rise,
    input  logic [DT_W-1:0] i_dt_fall,
    input  logic            i_pol_h,
    input  logic            i_pol_l,
    input  logic            i_upd_req,
    output logic            o_upd_ack,
    input  logic            i_flt_in,
    input  logic            i_flt_clr,
    output logic            o_flt_sts,
    output logic            o_pwm_h,
    output logic            o_pwm_l
);
    typedef enum logic [2:0] {IDLE, DT_RISE, HIGH, DT_FALL, LOW} state_t;

    state_t          r_state, w_nxt;
    logic [DT_W-1:0] r_cnt, w_cnt_nxt;
    logic [DT_W-1:0] r_dt_rise_s, r_dt_fall_s, w_dt_rise_n, w_dt_fall_n;
    logic            r_pol_h_s, r_pol_l_s, w_pol_h_n, w_pol_l_n;
    logic            r_upd_pend, r_upd_ack;
    logic            r_flt_s1, r_flt_s2, r_flt_sts;
    logic            r_pwm_h, r_pwm_l;
    logic            w_xfer, w_stop, w_go_rise, w_go_fall;

    // the period starting on the transfer edge already sees the new settings
    assign w_xfer      = (r_upd_pend | i_upd_req) & (i_period_evt | !i_pwm_en | r_state == IDLE);
    assign w_dt_rise_n = w_xfer ? i_dt_rise : r_dt_rise_s;
    assign w_dt_fall_n = w_xfer ? i_dt_fall : r_dt_fall_s;
    assign w_pol_h_n   = w_xfer ? i_pol_h : r_pol_h_s;
    assign w_pol_l_n   = w_xfer ? i_pol_l : r_pol_l_s;
    assign w_stop      = !i_pwm_en | r_flt_s2 | r_flt_sts;

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_go_rise = 1'b0;
        w_go_fall = 1'b0;
        case (r_state)
            IDLE: begin
                w_go_fall = i_period_evt & i_duty_evt;
                w_go_rise = i_period_evt & !i_duty_evt;
            end
            DT_RISE: begin
                if (i_duty_evt)               w_nxt = LOW;
                else if (r_cnt <= DT_W'(1))   w_nxt = HIGH;
                else                          w_cnt_nxt = r_cnt - DT_W'(1);
            end
            HIGH: w_go_fall = i_duty_evt;
            DT_FALL: begin
                if (i_period_evt & !i_duty_evt) w_go_rise = 1'b1;
                else if (r_cnt <= DT_W'(1))     w_nxt = LOW;
                else                            w_cnt_nxt = r_cnt - DT_W'(1);
            end
            LOW: w_go_rise = i_period_evt & !i_duty_evt;
            default: w_nxt = IDLE;
        endcase
        if (w_go_rise) begin
            w_nxt     = (w_dt_rise_n == '0) ? HIGH : DT_RISE;
            w_cnt_nxt = w_dt_rise_n;
        end
        if (w_go_fall) begin
            w_nxt     = (w_dt_fall_n == '0) ? LOW : DT_FALL;
            w_cnt_nxt = w_dt_fall_n;
        end
        if (w_stop) w_nxt = IDLE;
    end

    always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dt_rise_s <= '0;
            r_dt_fall_s <= '0;
            r_pol_h_s   <= 1'b0;
            r_pol_l_s   <= 1'b0;
            r_upd_pend  <= 1'b0;
            r_upd_ack   <= 1'b0;
            r_flt_s1    <= 1'b0;
            r_flt_s2    <= 1'b0;
            r_flt_sts   <= 1'b0;
            r_pwm_h     <= 1'b0;
            r_pwm_l     <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dt_rise_s <= w_dt_rise_n;
            r_dt_fall_s <= w_dt_fall_n;
            r_pol_h_s   <= w_pol_h_n;
            r_pol_l_s   <= w_pol_l_n;
            r_upd_pend  <= !w_xfer & (r_upd_pend | i_upd_req);
            r_upd_ack   <= w_xfer;
            r_flt_s1    <= i_flt_in;
            r_flt_s2    <= r_flt_s1;
            r_flt_sts   <= r_flt_s2 | (r_flt_sts & !i_flt_clr);
            r_pwm_h     <= (w_nxt == HIGH) ^ w_pol_h_n;
            r_pwm_l     <= (w_nxt == LOW) ^ w_pol_l_n;
        end
    end

    assign o_upd_ack = r_upd_ack;
    assign o_flt_sts = r_flt_sts;
    assign o_pwm_h   = r_pwm_h;
    assign o_pwm_l   = r_pwm_l;
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb_pwm_deadtime_gen: directed stimulus feeding a cycle-tagged expectation queue drained by a monitor
module tb_pwm_deadtime_gen;
    localparam int DT_W = 8;

    logic            pwm_clk = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            i_pwm_en = 1'b0, i_period_evt = 1'b0, i_duty_evt = 1'b0;
    logic [DT_W-1:0] i_dt_rise = '0, i_dt_fall = '0;
    logic            i_pol_h = 1'b0, i_pol_l = 1'b0, i_upd_req = 1'b0;
    logic            i_flt_in = 1'b0, i_flt_clr = 1'b0;
    logic            o_upd_ack, o_flt_sts, o_pwm_h, o_pwm_l;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit chk_ovl = 1'b0;

    typedef struct {
        int         c;
        int         kind;
        logic [1:0] v;
        string      name;
    } exp_t;
    exp_t q[$];

    pwm_deadtime_gen #(.DT_W(DT_W)) dut (
        .pwm_clk(pwm_clk), .sys_rst_n(sys_rst_n), .i_pwm_en(i_pwm_en),
        .i_period_evt(i_period_evt), .i_duty_evt(i_duty_evt),
        .i_dt_rise(i_dt_rise), .i_dt_fall(i_dt_fall), .i_pol_h(i_pol_h), .i_pol_l(i_pol_l),
        .i_upd_req(i_upd_req), .o_upd_ack(o_upd_ack), .i_flt_in(i_flt_in), .i_flt_clr(i_flt_clr),
        .o_flt_sts(o_flt_sts), .o_pwm_h(o_pwm_h), .o_pwm_l(o_pwm_l)
    );

    always #5 pwm_clk = ~pwm_clk;
    always @(posedge pwm_clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [1:0] act, logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endfunction

    function automatic void ex(int c0, int c1, logic h, logic l, string n);
        for (int c = c0; c <= c1; c++) q.push_back('{c, 0, {h, l}, n});
    endfunction

    function automatic void ea(int c, logic a, string n);
        q.push_back('{c, 1, {1'b0, a}, n});
    endfunction

    function automatic void es(int c, logic s, string n);
        q.push_back('{c, 2, {1'b0, s}, n});
    endfunction

    // outputs reflect the posedge numbered cyc when sampled on the following negedge
    always @(negedge pwm_clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].c < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s late cyc=%0d actual=unchecked required=%b", q[i].name, q[i].c, q[i].v);
                q.delete(i);
            end else if (q[i].c == cyc) begin
                if (q[i].kind == 0)      chk(q[i].name, {o_pwm_h, o_pwm_l}, q[i].v);
                else if (q[i].kind == 1) chk(q[i].name, {1'b0, o_upd_ack}, q[i].v);
                else                     chk(q[i].name, {1'b0, o_flt_sts}, q[i].v);
                q.delete(i);
            end
        end
        if (chk_ovl && sys_rst_n) chk("overlap", {1'b0, o_pwm_h & o_pwm_l}, 2'b00);
    end

    task automatic tick();
        @(posedge pwm_clk);
        #1;
    endtask

    task automatic go(input int c);
        while (cyc < c - 1) tick();
    endtask

    task automatic fire(input logic p, input logic d, input logic u, input logic c);
        i_period_evt = p;
        i_duty_evt   = d;
        i_upd_req    = u;
        i_flt_clr    = c;
        tick();
        i_period_evt = 1'b0;
        i_duty_evt   = 1'b0;
        i_upd_req    = 1'b0;
        i_flt_clr    = 1'b0;
    endtask

    initial begin
        int b, pp, qq, rr, ss, tt, uu, vv, ww, n;
        tick();
        tick();
        chk("rst_pwm", {o_pwm_h, o_pwm_l}, 2'b00);
        chk("rst_ack", {1'b0, o_upd_ack}, 2'b00);
        chk("rst_sts", {1'b0, o_flt_sts}, 2'b00);
        sys_rst_n = 1'b1;
        i_dt_rise = 8'd3;
        i_dt_fall = 8'd2;
        fire(0, 0, 1, 0);
        ea(cyc, 1, "ack_idle");
        ea(cyc + 1, 0, "ack_idle_end");
        i_pwm_en = 1'b1;
        chk_ovl  = 1'b1;
        b = cyc + 3;
        for (int k = 0; k < 2; k++) begin
            go(b + 20 * k); fire(1, 0, 0, 0);
            ex(b + 20 * k, b + 20 * k + 2, 0, 0, "rise_gap3");
            ex(b + 20 * k + 3, b + 20 * k + 7, 1, 0, "high5");
            go(b + 20 * k + 8); fire(0, 1, 0, 0);
            ex(b + 20 * k + 8, b + 20 * k + 9, 0, 0, "fall_gap2");
            ex(b + 20 * k + 10, b + 20 * k + 19, 0, 1, "low10");
        end
        // duty pulse shorter than a 5-cycle rise dead time
        i_dt_rise = 8'd5;
        go(b + 32); fire(0, 0, 1, 0);
        ea(b + 32, 0, "ack_pending");
        pp = b + 40;
        go(pp); fire(1, 0, 0, 0);
        ea(pp, 1, "ack_period");
        ea(pp + 1, 0, "ack_pulse_end");
        ex(pp, pp + 2, 0, 0, "short_rise");
        go(pp + 3); fire(0, 1, 0, 0);
        ex(pp + 3, pp + 9, 0, 1, "short_low");
        go(pp + 10); fire(1, 1, 0, 0);
        ex(pp + 10, pp + 13, 0, 1, "zero_duty_low");
        qq = pp + 14;
        go(qq); fire(1, 0, 0, 0);
        ex(qq, qq + 4, 0, 0, "rise5");
        ex(qq + 5, qq + 6, 1, 0, "high_dt5");
        go(qq + 7); fire(1, 1, 0, 0);
        ex(qq + 7, qq + 8, 0, 0, "zero_duty_fall");
        ex(qq + 9, qq + 11, 0, 1, "zero_duty_fall_low");
        i_dt_rise = 8'd2;
        go(qq + 12); fire(0, 0, 1, 0);
        ex(qq + 12, qq + 15, 0, 1, "low_pending");
        rr = qq + 16;
        go(rr); fire(1, 0, 0, 0);
        ea(rr, 1, "ack_dt2");
        ex(rr, rr + 1, 0, 0, "rise2");
        ex(rr + 2, rr + 3, 1, 0, "high_dt2");
        // mid-period request must not disturb the running period
        i_dt_rise = 8'd6;
        i_pol_h   = 1'b1;
        go(rr + 4); fire(0, 0, 1, 0);
        ea(rr + 4, 0, "ack_mid_none");
        ex(rr + 4, rr + 5, 1, 0, "high_unchanged");
        go(rr + 6); fire(0, 1, 0, 0);
        chk_ovl = 1'b0;
        ex(rr + 6, rr + 7, 0, 0, "fall_old");
        ex(rr + 8, rr + 11, 0, 1, "low_old_pol");
        ss = rr + 12;
        go(ss); fire(1, 0, 0, 0);
        ea(ss, 1, "ack_new_pol");
        ex(ss, ss + 5, 1, 0, "rise6_pol_idle");
        ex(ss + 6, ss + 7, 0, 0, "high_active_low");
        go(ss + 8); fire(0, 1, 0, 0);
        ex(ss + 8, ss + 9, 1, 0, "fall_pol");
        ex(ss + 10, ss + 11, 1, 1, "low_pol");
        i_dt_rise = 8'd3;
        i_pol_h   = 1'b0;
        go(ss + 12);
        i_pwm_en = 1'b0;
        fire(0, 0, 1, 0);
        ea(ss + 12, 1, "ack_disabled");
        ex(ss + 12, ss + 15, 0, 0, "disabled_idle");
        i_pwm_en = 1'b1;
        chk_ovl  = 1'b1;
        // fault while HIGH, clear attempted while still faulted, then real clear
        tt = ss + 16;
        go(tt); fire(1, 0, 0, 0);
        ex(tt, tt + 2, 0, 0, "rise_pre_flt");
        ex(tt + 3, tt + 4, 1, 0, "high_pre_flt");
        go(tt + 5);
        i_flt_in = 1'b1;
        ex(tt + 5, tt + 6, 1, 0, "high_flt_sync");
        es(tt + 6, 0, "sts_pre_flt");
        ex(tt + 7, tt + 13, 0, 0, "flt_off");
        es(tt + 7, 1, "sts_set");
        go(tt + 8);
        i_flt_in = 1'b0;
        fire(0, 0, 0, 1);
        es(tt + 8, 1, "clr_ignored");
        es(tt + 9, 1, "sts_sticky");
        go(tt + 10); fire(1, 0, 0, 0);
        es(tt + 11, 1, "sts_hold");
        go(tt + 12); fire(0, 0, 0, 1);
        es(tt + 12, 0, "sts_clr");
        uu = tt + 14;
        go(uu); fire(1, 0, 0, 0);
        ex(uu, uu + 5, 0, 0, "en_drop_rise");
        go(uu + 2);
        i_pwm_en = 1'b0;
        go(uu + 4); fire(1, 0, 0, 0);
        i_pwm_en = 1'b1;
        vv = uu + 7;
        go(vv); fire(1, 0, 0, 0);
        ex(vv, vv + 2, 0, 0, "rise_resume");
        ex(vv + 3, vv + 3, 1, 0, "high_resume");
        go(vv + 4); fire(0, 0, 1, 0);
        chk("high_pre_rst", {o_pwm_h, o_pwm_l}, 2'b10);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", {o_pwm_h, o_pwm_l}, 2'b00);
        chk("async_rst_ack", {1'b0, o_upd_ack}, 2'b00);
        chk("async_rst_sts", {1'b0, o_flt_sts}, 2'b00);
        tick();
        tick();
        sys_rst_n = 1'b1;
        // zero shadow dead times after reset: outputs switch on the event edge
        ww = cyc + 3;
        go(ww); fire(1, 0, 0, 0);
        ea(ww, 0, "no_ack_after_rst");
        es(ww, 0, "sts_after_rst");
        ex(ww, ww + 2, 1, 0, "dt0_high");
        go(ww + 3); fire(0, 1, 0, 0);
        ex(ww + 3, ww + 5, 0, 1, "dt0_low");
        n = 0;
        while (q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
